ac97_sample_buffer: RTL and testbench

Elastic output stage directly downstream of the effects chain. It absorbs 12-bit processed samples, which arrive with a one-cycle valid pulse whenever the chain finishes a sample. It releases one sample per AC97 frame-ready strobe as a left-justified 20-bit slot value. It decouples chain completion timing from the codec frame rate and handles underrun by priming and repeating the last sample, and overflow by dropping input. Sticky status flags are provided for debug LEDs.

---
 rtl/ac97_sample_buffer_pkg.sv | 31 +++
 rtl/sample_fifo_mem.sv | 33 +++
 rtl/ac97_sample_buffer.sv | 179 +++++++++++++++++
 tb/tb_ac97_sample_buffer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac97_sample_buffer_pkg.sv
// Shared audio definitions for the AC97 output sample buffer.
// State encoding, slot widths and default buffer sizing.
package ac97_sample_buffer_pkg;

  localparam int SAMPLE_W = 12;
  localparam int AC97_W   = 20;
  localparam int AC97_PAD = 8;

  localparam int DEFAULT_DEPTH_LOG2  = 4;
  localparam int DEFAULT_PRIME_LEVEL = 8;

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

  // Which register currently feeds the slot output.
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_FIFO,
    SRC_LAST
  } out_src_t;

  // Left-justify a 12-bit sample into a 20-bit AC97 slot.
  function automatic logic [AC97_W-1:0] to_slot(
    input logic [SAMPLE_W-1:0] s
  );
    return {s, {AC97_PAD{1'b0}}};
  endfunction

endpackage

// File: rtl/sample_fifo_mem.sv
// Simple dual-port sample RAM for the AC97 buffer.
// One write port, one read port with registered, enabled read data.
module sample_fifo_mem #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 12
) (
  input  logic                  clock,
  input  logic                  i_wr_en,
  input  logic [DEPTH_LOG2-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  input  logic [DEPTH_LOG2-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [WIDTH-1:0] r_rd_data;

  // Write port plus read port; read data holds until the next read.
  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ac97_sample_buffer.sv
// Elastic buffer between the effects chain and the AC97 slot output.
// Optional macro SOFT_FADE_EN: decaying tail on underrun and in PRIME.
module ac97_sample_buffer
  import ac97_sample_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
  parameter int PRIME_LEVEL = DEFAULT_PRIME_LEVEL
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_in_valid,
  input  logic                       ac97_ready,
  input  logic                       clear_flags,
  output logic signed [AC97_W-1:0]   ac97_out,
  output logic                       ac97_out_valid,
  output logic [DEPTH_LOG2:0]        fifo_level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_PRIME = LVL_W'(PRIME_LEVEL);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  state_t                     r_state;
  out_src_t                   r_src;
  logic [DEPTH_LOG2-1:0]      r_wr_ptr;
  logic [DEPTH_LOG2-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]           r_level;
  logic signed [SAMPLE_W-1:0] r_last;
  logic                       r_valid;
  logic                       r_pop_d;
  logic                       r_ovf;
  logic                       r_udf;

  logic [SAMPLE_W-1:0] w_rd_data;
  logic [SAMPLE_W-1:0] w_slot_sample;
  logic                w_strobe;
  logic                w_empty;
  logic                w_run;
  logic                w_pop;
  logic                w_underrun;
  logic                w_push;
  logic                w_drop;

`ifdef SOFT_FADE_EN
  logic signed [SAMPLE_W-1:0] w_fade;
  assign w_fade = r_last >>> 1;
`endif

  // A strobe arriving while the previous output pulse is up is ignored.
  assign w_strobe   = ac97_ready & ~r_valid;
  assign w_empty    = (r_level == '0);
  assign w_run      = (r_state == RUN);
  assign w_pop      = w_strobe & w_run & ~w_empty;
  assign w_underrun = w_strobe & w_run & w_empty;
  assign w_push     = sample_in_valid
                    & ((r_level != LVL_FULL) | w_pop);
  assign w_drop     = sample_in_valid & ~w_push;

  sample_fifo_mem #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (SAMPLE_W)
  ) u_mem (
    .clock    (clock),
    .i_wr_en  (w_push),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(sample_in),
    .i_rd_en  (w_pop),
    .i_rd_addr(r_rd_ptr),
    .o_rd_data(w_rd_data)
  );

  // Circular pointers and the occupancy counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: ;
      endcase
    end
  end

  // PRIME/RUN sequencing, output source selection and last sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= PRIME;
      r_src   <= SRC_ZERO;
      r_valid <= 1'b0;
      r_pop_d <= 1'b0;
      r_last  <= '0;
    end else begin
      r_valid <= w_strobe;
      r_pop_d <= w_pop;
      if (r_pop_d) begin
        r_last <= w_rd_data;
      end
      unique case (r_state)
        PRIME: begin
          if (w_strobe) begin
`ifdef SOFT_FADE_EN
            r_src  <= SRC_LAST;
            r_last <= w_fade;
`else
            r_src  <= SRC_ZERO;
`endif
          end
          if (r_level >= LVL_PRIME) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_pop) begin
            r_src <= SRC_FIFO;
          end else if (w_underrun) begin
            r_src   <= SRC_LAST;
            r_state <= PRIME;
`ifdef SOFT_FADE_EN
            r_last  <= w_fade;
`endif
          end
        end
        default: r_state <= PRIME;
      endcase
    end
  end

  // Sticky debug flags; a same-cycle event beats the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clear_flags) begin
        r_ovf <= 1'b0;
      end
      if (w_underrun) begin
        r_udf <= 1'b1;
      end else if (clear_flags) begin
        r_udf <= 1'b0;
      end
    end
  end

  // Slot data is picked from registers only, so it holds between pulses.
  always_comb begin
    w_slot_sample = '0;
    unique case (r_src)
      SRC_FIFO: w_slot_sample = w_rd_data;
      SRC_LAST: w_slot_sample = r_last;
      default:  w_slot_sample = '0;
    endcase
  end

  assign ac97_out       = to_slot(w_slot_sample);
  assign ac97_out_valid = r_valid;
  assign fifo_level     = r_level;
  assign overflow       = r_ovf;
  assign underflow      = r_udf;

endmodule

// File: tb/tb_ac97_sample_buffer.sv
// Self-checking bench for ac97_sample_buffer against a queue model.
// Define SOFT_FADE_EN here and in the RTL to check the fade build.
module tb_ac97_sample_buffer;

  localparam int DEPTH = 16;
  localparam int PRIME_LEVEL = 8;

  logic        clock;
  logic        reset;
  logic [11:0] sample_in;
  logic        sample_in_valid;
  logic        ac97_ready;
  logic        clear_flags;
  logic [19:0] ac97_out;
  logic        ac97_out_valid;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        underflow;

  int errors = 0;
  int checks = 0;

  logic [11:0]        q[$];
  bit                 m_run;
  logic signed [11:0] m_last;
  logic [19:0]        m_out;
  bit                 m_valid;
  bit                 m_ovf;
  bit                 m_udf;

  ac97_sample_buffer #(
    .DEPTH_LOG2 (4),
    .PRIME_LEVEL(PRIME_LEVEL)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .sample_in      (sample_in),
    .sample_in_valid(sample_in_valid),
    .ac97_ready     (ac97_ready),
    .clear_flags    (clear_flags),
    .ac97_out       (ac97_out),
    .ac97_out_valid (ac97_out_valid),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("valid", 32'(ac97_out_valid), 32'(m_valid));
    chk("out", 32'(ac97_out), 32'(m_out));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_in = '0;
    sample_in_valid = 1'b0;
    ac97_ready = 1'b0;
    clear_flags = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    m_run = 1'b0;
    m_last = '0;
    m_out = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_all();
  endtask

  // One clock with the given inputs; model advanced from spec rules.
  task automatic step(input logic vin, input logic [11:0] din,
                      input logic rdy, input logic clr);
    bit strobe, pop, under, push, drop;
    int lvl;
    sample_in = din;
    sample_in_valid = vin;
    ac97_ready = rdy;
    clear_flags = clr;
    lvl = q.size();
    strobe = rdy && !m_valid;
    pop = strobe && m_run && lvl > 0;
    under = strobe && m_run && lvl == 0;
    push = vin && (lvl < DEPTH || pop);
    drop = vin && !push;
    m_valid = strobe;
    if (pop) begin
      m_last = q.pop_front();
      m_out = {m_last, 8'h00};
    end else if (strobe) begin
`ifdef SOFT_FADE_EN
      m_last = m_last >>> 1;
      m_out = {m_last, 8'h00};
`else
      m_out = under ? {m_last, 8'h00} : 20'h0;
`endif
    end
    if (push) q.push_back(din);
    if (under) m_run = 1'b0;
    else if (!m_run && lvl >= PRIME_LEVEL) m_run = 1'b1;
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (under) m_udf = 1'b1;
    else if (clr) m_udf = 1'b0;
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic wr(input logic [11:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic strobe1();
    step(1'b0, 12'h0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 12'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int sent;
    reset = 1'b1;
    sample_in = '0;
    sample_in_valid = 1'b0;
    ac97_ready = 1'b0;
    clear_flags = 1'b0;
    @(posedge clock);
    #1;

    // Priming: strobe below prime level gives 0, then first sample.
    do_reset();
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_out", 32'(ac97_out), 32'd0);
    for (int i = 0; i < 7; i++) wr(12'(12'h100 + i));
    strobe1();
    chk("prime_out", 32'(ac97_out), 32'h0);
    chk("prime_valid", 32'(ac97_out_valid), 32'd1);
    idle(1);
    wr(12'h107);
    idle(2);
    strobe1();
    chk("first_out", 32'(ac97_out), 32'h10000);
    chk("first_level", 32'(fifo_level), 32'd7);
    idle(3);
    chk("hold_out", 32'(ac97_out), 32'h10000);

    // Overflow, clear, and full with simultaneous write and pop.
    do_reset();
    for (int i = 0; i < 16; i++) wr(12'(12'h200 + i));
    wr(12'h7FF);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(fifo_level), 32'd16);
    step(1'b0, 12'h0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    step(1'b1, 12'h7AA, 1'b1, 1'b0);
    chk("full_rw_level", 32'(fifo_level), 32'd16);
    chk("full_rw_ovf", 32'(overflow), 32'd0);
    chk("full_rw_out", 32'(ac97_out), 32'h20000);
    idle(1);
    step(1'b1, 12'h123, 1'b0, 1'b1);
    chk("ovf_evt_wins", 32'(overflow), 32'd1);

    // Underrun: last sample -1 repeated, underflow set.
    do_reset();
    for (int i = 0; i < 7; i++) wr(12'(12'h010 + i));
    wr(12'hFFF);
    idle(2);
    for (int i = 0; i < 7; i++) begin
      strobe1();
      idle(1);
    end
    chk("udf_level1", 32'(fifo_level), 32'd1);
    strobe1();
    chk("udf_last_out", 32'(ac97_out), 32'hFFF00);
    idle(1);
    strobe1();
    chk("udf_rep_out", 32'(ac97_out), 32'hFFF00);
    chk("udf_flag", 32'(underflow), 32'd1);
    idle(1);
    step(1'b0, 12'h0, 1'b0, 1'b1);
    chk("udf_clr", 32'(underflow), 32'd0);

    // Wrap: 40 random samples streamed through, checked in order.
    do_reset();
    sent = 0;
    for (int c = 0; c < 120; c++) begin
      bit v, r;
      v = (c % 2 == 0) && (sent < 40);
      r = (c % 2 == 1) && (c > 20);
      if (v) sent++;
      step(v, 12'($urandom), r, 1'b0);
    end
    chk("wrap_ovf", 32'(overflow), 32'd0);

    // Mid-stream reset at level 5.
    do_reset();
    for (int i = 0; i < 5; i++) wr(12'($urandom));
    chk("mid_level5", 32'(fifo_level), 32'd5);
    do_reset();
    chk("mid_level0", 32'(fifo_level), 32'd0);
    chk("mid_out0", 32'(ac97_out), 32'd0);
    strobe1();
    chk("mid_strobe_out", 32'(ac97_out), 32'd0);

    // Underrun tail from last = 0x400.
    do_reset();
    for (int i = 0; i < 7; i++) wr(12'(12'h050 + i));
    wr(12'h400);
    idle(2);
    for (int i = 0; i < 8; i++) begin
      strobe1();
      idle(1);
    end
    chk("tail_last", 32'(ac97_out), 32'h40000);
    strobe1();
`ifdef SOFT_FADE_EN
    chk("fade_1", 32'(ac97_out), 32'h20000);
`else
    chk("tail_1", 32'(ac97_out), 32'h40000);
`endif
    idle(1);
    strobe1();
`ifdef SOFT_FADE_EN
    chk("fade_2", 32'(ac97_out), 32'h10000);
`else
    chk("tail_2", 32'(ac97_out), 32'h0);
`endif
    idle(1);
    strobe1();
`ifdef SOFT_FADE_EN
    chk("fade_3", 32'(ac97_out), 32'h08000);
`else
    chk("tail_3", 32'(ac97_out), 32'h0);
`endif

    // Random traffic: overfed, then underfed.
    do_reset();
    for (int c = 0; c < 300; c++)
      step(($urandom % 3) == 0, 12'($urandom),
           ($urandom % 4) == 0, ($urandom % 16) == 0);
    for (int c = 0; c < 300; c++)
      step(($urandom % 5) == 0, 12'($urandom),
           ($urandom % 2) == 0, ($urandom % 16) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
